uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (valid/ready byte interface, same handshake style as the UART receiver's output) between REQ_NUM byte-stream requesters. It grants requesters round-robin and keeps the grant for a whole frame, delimited by req_last, so frames never interleave on the serial line. A hold timeout releases the line if the granted requester stalls mid-frame. It sits between protocol/reply generators and uart_tx in the UART test design.

Parameters:
REQ_NUM, 4, number of requesters (2..8).
IDLE_TIMEOUT, 5000, clk cycles a granted requester may leave req_valid low mid-frame before the grant is revoked (1..65535).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
req_valid  input  REQ_NUM  per-requester byte valid, held until req_ready.
req_last  input  REQ_NUM  byte is the final byte of the frame.
req_data  input  8*REQ_NUM  packed bytes; requester i uses bits [8i+7:8i].
req_ready  output  REQ_NUM  one-cycle pulse: byte captured.
grant  output  REQ_NUM  one-hot owner of the line; all zero when idle.
busy  output  1  high whenever grant is non-zero.
tx_data  output  8  byte to uart_tx.
tx_data_valid  output  1  byte valid to uart_tx, held until tx_data_ready.
tx_data_ready  input  1  uart_tx accepted the byte.
timeout_err  output  1  one-cycle pulse: grant revoked by timeout.

Behaviour:
- Reset values: req_ready=0, grant=0, busy=0, tx_data=0, tx_data_valid=0, timeout_err=0. State=IDLE, last_grant=REQ_NUM-1 so requester 0 has highest priority first. hold_cnt=0, cur_last=0.
- Reset mid-frame aborts immediately. The byte in flight is dropped and the requester must restart its frame.
- States: IDLE, SEND, HOLD. All outputs are registered.
- IDLE: if any req_valid, pick the first asserted index scanning last_grant+1, +2, ... cyclically. On that edge:
  - capture its data into tx_data and its req_last into cur_last;
  - set grant to that one-hot, set tx_data_valid=1, pulse req_ready for that index;
  - go to SEND.
  - Latency: req_valid high in cycle t gives tx_data_valid, grant and req_ready high in cycle t+1.
- req_ready rule: high exactly one cycle per captured byte. The requester must present its next byte or drop req_valid on the edge ending that cycle. The arbiter never samples req_* while in SEND.
- SEND: hold tx_data and tx_data_valid until tx_data_ready=1 is sampled. On that edge clear tx_data_valid. Then:
  - if cur_last=1: go to IDLE, clear grant, set last_grant to the granted index;
  - otherwise: go to HOLD and clear hold_cnt.
- HOLD: only the granted requester is looked at.
  - If its req_valid=1: capture the byte and last flag, pulse req_ready, set tx_data_valid=1, go to SEND. Latency is 1 cycle.
  - Otherwise hold_cnt increments. When hold_cnt==IDLE_TIMEOUT-1 with valid still low: go to IDLE, clear grant, update last_grant, pulse timeout_err. The rest of the frame then arrives as a new arbitration request.
- Grant never changes while in SEND or HOLD. Other requesters' valid are ignored there and they wait with valid held.
- Simultaneous requests in IDLE: round-robin decides, and the loser is served in the very next IDLE (zero extra idle cycles beyond the single IDLE cycle).
- Boundary and error cases:
  - tx_data_ready while tx_data_valid=0 is ignored.
  - A single-byte frame (req_last=1 on the first byte) returns to IDLE after one SEND.
  - A requester deasserting req_valid without a req_ready pulse is a protocol error and is not guarded.
- hold_cnt is 16 bits. Throughput is at most one byte per 2 cycles, which is irrelevant next to the UART bit time.

Test Plan:
- Single frame: requester 1 sends 0x55,0xAA(last); tx_data_ready pulses 3 cycles after each valid -> tx bytes 0x55 then 0xAA, grant=4'b0010 throughout, grant=0 one cycle after the second ready, two req_ready pulses.
- Round-robin: requesters 0 and 2 both request 1-byte frames (0x11, 0x33) at the same cycle after reset -> 0x11 sent first, then 0x33; repeat both -> 0x11 before 0x33 again (last_grant=2 gives priority to 3,0,...).
- Atomicity: requester 0 sends 3-byte frame 0x01,0x02,0x03; requester 3 raises valid with 0xF0 during byte 2 -> tx order 0x01,0x02,0x03,0xF0; req_ready[3] only after the frame ends.
- Timeout (IDLE_TIMEOUT=8): requester 2 sends 0xA0 (not last), then holds valid low -> timeout_err pulses exactly 8 cycles after the HOLD entry, grant=0; a later 0xA1(last) from requester 2 is re-arbitrated and sent.
- Backpressure: tx_data_ready held low 100 cycles -> tx_data and tx_data_valid stable, no further req_ready, hold_cnt not counting.
- Reset mid-frame: assert rst during SEND -> all outputs 0 asynchronously; after release requester 0 wins the first arbitration.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame arbiter sharing one UART transmitter
// The grant is held from the first byte of a frame until req_last or a hold timeout.
module uart_tx_arbiter #(
    parameter int REQ_NUM      = 4,
    parameter int IDLE_TIMEOUT = 5000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_NUM-1:0]   req_valid,
    input  logic [REQ_NUM-1:0]   req_last,
    input  logic [8*REQ_NUM-1:0] req_data,
    output logic [REQ_NUM-1:0]   req_ready,
    output logic [REQ_NUM-1:0]   grant,
    output logic                 busy,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic                 timeout_err
);
    localparam int                 IW         = $clog2(REQ_NUM);
    localparam logic [REQ_NUM-1:0] ONE        = REQ_NUM'(1);
    localparam logic [15:0]        HOLD_LIMIT = 16'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_HOLD = 2'd2} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_last_grant;
    logic [IW-1:0]      r_gnt_idx;
    logic [IW-1:0]      w_pick_idx;
    logic [IW-1:0]      w_sel_idx;
    logic               w_pick_found;
    int                 w_dist;
    int                 w_best_dist;
    logic [15:0]        r_hold_cnt;
    logic               r_cur_last;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;
    logic               w_sel_valid;
    logic [REQ_NUM-1:0] w_sel_onehot;
    logic               w_hold_expired;

    // Round-robin: smallest cyclic distance past the last owner wins.
    always_comb begin
        w_pick_idx   = r_last_grant;
        w_best_dist  = REQ_NUM;
        w_dist       = 0;
        w_pick_found = |req_valid;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_dist = (i + 2 * REQ_NUM - 1 - int'(r_last_grant)) % REQ_NUM;
            if (req_valid[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_pick_idx  = IW'(i);
            end
        end
    end

    // In IDLE the arbitration winner is read; otherwise only the owner is looked at.
    always_comb begin
        w_sel_idx   = (r_state == S_IDLE) ? w_pick_idx : r_gnt_idx;
        w_sel_data  = 8'h00;
        w_sel_last  = 1'b0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_sel_idx == IW'(i)) begin
                w_sel_data  = req_data[8*i +: 8];
                w_sel_last  = req_last[i];
                w_sel_valid = req_valid[i];
            end
        end
        w_sel_onehot   = ONE << w_sel_idx;
        w_hold_expired = (r_hold_cnt == HOLD_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_pick_found) w_state_nxt = S_SEND;
            S_SEND: if (tx_data_ready) w_state_nxt = r_cur_last ? S_IDLE : S_HOLD;
            S_HOLD: begin
                if (w_sel_valid) begin
                    w_state_nxt = S_SEND;
                end else if (w_hold_expired) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready     <= '0;
            grant         <= '0;
            busy          <= 1'b0;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            timeout_err   <= 1'b0;
            r_last_grant  <= IW'(REQ_NUM - 1);
            r_gnt_idx     <= '0;
            r_hold_cnt    <= '0;
            r_cur_last    <= 1'b0;
        end else begin
            req_ready   <= '0;
            timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        tx_data       <= w_sel_data;
                        r_cur_last    <= w_sel_last;
                        tx_data_valid <= 1'b1;
                        req_ready     <= w_sel_onehot;
                        grant         <= w_sel_onehot;
                        busy          <= 1'b1;
                        r_gnt_idx     <= w_pick_idx;
                    end
                end
                S_SEND: begin
                    if (tx_data_ready) begin
                        tx_data_valid <= 1'b0;
                        if (r_cur_last) begin
                            grant        <= '0;
                            busy         <= 1'b0;
                            r_last_grant <= r_gnt_idx;
                        end else begin
                            r_hold_cnt <= '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_sel_valid) begin
                        tx_data       <= w_sel_data;
                        r_cur_last    <= w_sel_last;
                        tx_data_valid <= 1'b1;
                        req_ready     <= w_sel_onehot;
                    end else if (w_hold_expired) begin
                        grant        <= '0;
                        busy         <= 1'b0;
                        r_last_grant <= r_gnt_idx;
                        timeout_err  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic [7:0]     tx_data;
    logic           tx_data_valid;
    logic           tx_data_ready = 1'b0;
    logic           timeout_err;

    uart_tx_arbiter #(.REQ_NUM(N), .IDLE_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .grant(grant), .busy(busy),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] rq [N][$];
    logic [7:0] fr [N][$];
    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    int         rr_cnt [N];
    int         m_last = N - 1;
    int         sink_wait = 0;
    int         accept_cyc = 0;
    logic       hold_off = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester agents and the transmitter sink, all driven on the falling edge.
    initial begin
        logic [8:0] ent;
        for (int i = 0; i < N; i++) rr_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        rr_cnt[i]++;
                        req_valid[i] = 1'b0;
                    end
                    if (!req_valid[i] && rq[i].size() > 0) begin
                        ent = rq[i].pop_front();
                        req_valid[i]       = 1'b1;
                        req_last[i]        = ent[8];
                        req_data[8*i +: 8] = ent[7:0];
                    end
                end
                if (tx_data_ready) begin
                    tx_data_ready = 1'b0;
                    sink_wait     = int'($urandom_range(0, 3));
                end else if (tx_data_valid && !hold_off) begin
                    if (sink_wait == 0) begin
                        tx_data_ready = 1'b1;
                        act_q.push_back(tx_data);
                        accept_cyc = cyc + 1;
                    end else begin
                        sink_wait--;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input int i, input logic [7:0] d, input logic last);
        rq[i].push_back({last, d});
        fr[i].push_back(d);
    endtask

    task automatic rand_frame(input int i, input int len);
        for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
    endtask

    // Reference: whole frames leave in cyclic order after the previous owner.
    task automatic rr_model(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        pend = mask;
        while (pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (pend[idx]) begin
                    while (fr[idx].size() > 0) exp_q.push_back(fr[idx].pop_front());
                    pend[idx] = 1'b0;
                    m_last    = idx;
                    break;
                end
            end
        end
    endtask

    task automatic clear_tb();
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            fr[i].delete();
        end
        req_valid     = '0;
        req_last      = '0;
        req_data      = '0;
        tx_data_ready = 1'b0;
        hold_off      = 1'b0;
        sink_wait     = 0;
        exp_q.delete();
        act_q.delete();
        m_last = N - 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        clear_tb();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input logic [N-1:0] allowed, input string tag);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (!(act_q.size() >= exp_q.size() && grant == '0 && !tx_data_valid) && n < 3000) begin
            @(negedge clk);
            n++;
            if ((grant & ~allowed) != '0 || $countones(grant) > 1) bad++;
        end
        check({tag, "_timely"}, 32'(n < 3000), 32'd1);
        check({tag, "_grant_owner"}, 32'(bad), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++)
            check({tag, "_byte"}, 32'(act_q[k]), 32'(exp_q[k]));
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_data_valid), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        int b0;
        int b1;
        int b3;
        logic [7:0] d0;
        logic [N-1:0] mask;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single two-byte frame from requester 1, with first-byte latency.
        @(posedge clk);
        #1;
        b1 = rr_cnt[1];
        push_byte(1, 8'h55, 1'b0);
        push_byte(1, 8'hAA, 1'b1);
        rr_model(4'b0010);
        @(negedge clk);
        @(negedge clk);
        check("single_lat_valid", 32'(tx_data_valid), 32'd1);
        check("single_lat_grant", 32'(grant), 32'h2);
        check("single_lat_ready", 32'(req_ready), 32'h2);
        check("single_lat_data", 32'(tx_data), 32'h55);
        wait_done(4'b0010, "single");
        check("single_ready_pulses", 32'(rr_cnt[1] - b1), 32'd2);

        // Simultaneous single-byte frames from 0 and 2, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_byte(0, 8'h11, 1'b1);
            push_byte(2, 8'h33, 1'b1);
            rr_model(4'b0101);
            wait_done(4'b0101, "rr_pair");
        end

        // Random contending frame sets.
        for (int r = 0; r < 6; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (mask[i]) rand_frame(i, int'($urandom_range(1, 3)));
            rr_model(mask);
            wait_done(mask, "rr_rand");
        end

        // Frame atomicity against a late requester.
        b0 = rr_cnt[0];
        b3 = rr_cnt[3];
        push_byte(0, 8'h01, 1'b0);
        push_byte(0, 8'h02, 1'b0);
        push_byte(0, 8'h03, 1'b1);
        rr_model(4'b0001);
        n = 0;
        while (rr_cnt[0] < b0 + 2 && n < 200) begin @(negedge clk); n++; end
        push_byte(3, 8'hF0, 1'b1);
        rr_model(4'b1000);
        n = 0;
        while (rr_cnt[0] < b0 + 3 && n < 200) begin @(negedge clk); n++; end
        check("atom_third_byte_seen", 32'(n < 200), 32'd1);
        check("atom_no_early_ready3", 32'(rr_cnt[3] - b3), 32'd0);
        wait_done(4'b1001, "atom");
        check("atom_ready3_once", 32'(rr_cnt[3] - b3), 32'd1);

        // Hold timeout with the rest of the frame re-arbitrated.
        push_byte(2, 8'hA0, 1'b0);
        rr_model(4'b0100);
        n = 0;
        while (!timeout_err && n < 300) begin @(negedge clk); n++; end
        check("tmo_seen", 32'(timeout_err), 32'd1);
        check("tmo_latency", 32'(cyc - accept_cyc), 32'(TMO));
        check("tmo_grant", 32'(grant), 32'd0);
        check("tmo_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("tmo_pulse_width", 32'(timeout_err), 32'd0);
        push_byte(2, 8'hA1, 1'b1);
        rr_model(4'b0100);
        wait_done(4'b0100, "tmo");

        // Backpressure: 100 cycles without tx_data_ready.
        hold_off = 1'b1;
        rand_frame(1, 2);
        rr_model(4'b0010);
        n = 0;
        while (!tx_data_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_valid_seen", 32'(tx_data_valid), 32'd1);
        @(negedge clk);
        b1  = rr_cnt[1];
        d0  = tx_data;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_data !== d0 || tx_data_valid !== 1'b1 || rr_cnt[1] != b1 || timeout_err !== 1'b0) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        check("bp_first_byte", 32'(d0), 32'(exp_q[0]));
        hold_off = 1'b0;
        wait_done(4'b0010, "bp");

        // Asynchronous reset in SEND, then requester 0 wins first.
        hold_off = 1'b1;
        rand_frame(2, 3);
        n = 0;
        while (!tx_data_valid && n < 50) begin @(negedge clk); n++; end
        check("mid_rst_in_send", 32'(tx_data_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        clear_tb();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rand_frame(3, 1);
        rand_frame(0, 1);
        rr_model(4'b1001);
        wait_done(4'b1001, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
